// File: rtl/irq_latch_4.sv
// Four-channel interrupt latch. Each channel captures request edges or levels,
// holds them until acknowledged, and flags a sticky overflow on a lost edge.

module irq_latch_4_lane #(
    parameter int EDGE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic clr,
    input  logic ovf_clr,
    output logic raw,
    output logic ovf
);
    logic req_q;
    logic set;

    // History keeps loading through reset so a line held high across
    // reset release is not mistaken for a fresh rising edge.
    always_ff @(posedge clk) begin
        req_q <= req;
    end

    assign set = (EDGE != 0) ? (req & ~req_q) : req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raw <= 1'b0;
            ovf <= 1'b0;
        end else begin
            raw <= set | (raw & ~clr);
            // A new overflow beats a same-cycle clear; level mode never overflows.
            if ((EDGE != 0) && set && raw && !clr)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end
endmodule

module irq_latch_4 #(
    parameter int EDGE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] mask,
    input  logic       ack,
    input  logic [1:0] ack_idx,
    input  logic       ovf_clr,
    output logic [3:0] pend,
    output logic       irq,
    output logic [3:0] ovf,
    output logic [2:0] pend_cnt
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0] raw;
    logic [NUM_LANES-1:0] clr;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign clr[i] = ack && (ack_idx == 2'(i));

        irq_latch_4_lane #(.EDGE(EDGE)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (req[i]),
            .clr     (clr[i]),
            .ovf_clr (ovf_clr),
            .raw     (raw[i]),
            .ovf     (ovf[i])
        );
    end

    // Masking only gates the view; latched events survive while masked.
    assign pend = raw & mask;
    assign irq  = |pend;

    always_comb begin
        pend_cnt = 3'd0;
        for (int i = 0; i < NUM_LANES; i++)
            pend_cnt = pend_cnt + {2'b00, pend[i]};
    end
endmodule

// File: tb/tb_irq_latch_4.sv
// Directed bench for irq_latch_4: edge-mode and level-mode instances share stimulus.

module tb_irq_latch_4;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_idx;
    logic       ovf_clr;

    logic [3:0] e1_pend, e1_ovf, e0_pend, e0_ovf;
    logic       e1_irq, e0_irq;
    logic [2:0] e1_cnt, e0_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_latch_4 #(.EDGE(1)) dut_e1 (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack),
        .ack_idx(ack_idx), .ovf_clr(ovf_clr),
        .pend(e1_pend), .irq(e1_irq), .ovf(e1_ovf), .pend_cnt(e1_cnt)
    );

    irq_latch_4 #(.EDGE(0)) dut_e0 (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack),
        .ack_idx(ack_idx), .ovf_clr(ovf_clr),
        .pend(e0_pend), .irq(e0_irq), .ovf(e0_ovf), .pend_cnt(e0_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Full view of the edge-mode instance.
    task automatic chk_e1(input string tag, input logic [3:0] p, input logic [2:0] c,
                          input logic [3:0] o);
        chk({tag, ".pend"}, e1_pend, p);
        chk({tag, ".irq"}, {3'b000, e1_irq}, {3'b000, |p});
        chk({tag, ".cnt"}, {1'b0, e1_cnt}, {1'b0, c});
        chk({tag, ".ovf"}, e1_ovf, o);
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b1111; mask = 4'b1111;
        ack = 1'b0; ack_idx = 2'd0; ovf_clr = 1'b0;
        tick(); tick();
        chk_e1("reset", 4'b0000, 3'd0, 4'b0000);

        // Requests held through reset release must not fire.
        rst_n = 1'b1;
        tick();
        chk_e1("release", 4'b0000, 3'd0, 4'b0000);
        tick(); tick();
        chk_e1("held_hi", 4'b0000, 3'd0, 4'b0000);

        // Single rising edge, then held.
        req = 4'b0000; tick();
        req = 4'b0100; tick();
        chk_e1("rise2", 4'b0100, 3'd1, 4'b0000);
        tick();
        chk_e1("hold2", 4'b0100, 3'd1, 4'b0000);
        ack = 1'b1; ack_idx = 2'd2; tick(); ack = 1'b0;
        chk_e1("ack2", 4'b0000, 3'd0, 4'b0000);

        // Two pending, acked one at a time.
        req = 4'b1010; tick();
        chk_e1("rise31", 4'b1010, 3'd2, 4'b0000);
        ack = 1'b1; ack_idx = 2'd3; tick();
        chk_e1("ack3", 4'b0010, 3'd1, 4'b0000);
        ack_idx = 2'd1; tick(); ack = 1'b0;
        chk_e1("ack1", 4'b0000, 3'd0, 4'b0000);

        // Event latched while masked appears on unmask with no new edge.
        req = 4'b0000; tick();
        mask = 4'b1011; req = 4'b0100; tick();
        chk_e1("masked", 4'b0000, 3'd0, 4'b0000);
        mask = 4'b1111; #1;
        chk_e1("unmask", 4'b0100, 3'd1, 4'b0000);
        ack = 1'b1; ack_idx = 2'd2; tick(); ack = 1'b0;
        // Ack to a non-pending channel is harmless.
        ack = 1'b1; ack_idx = 2'd0; tick(); ack = 1'b0;
        chk_e1("ack_idle", 4'b0000, 3'd0, 4'b0000);

        // Overflow on re-rise without ack.
        req = 4'b0000; tick();
        req = 4'b0001; tick();
        chk_e1("rise0", 4'b0001, 3'd1, 4'b0000);
        req = 4'b0000; tick();
        req = 4'b0001; tick();
        chk_e1("ovf0", 4'b0001, 3'd1, 4'b0001);
        chk("e0.ovf_never", e0_ovf, 4'b0000);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk_e1("ovf_clr", 4'b0001, 3'd1, 4'b0000);

        // Re-rise with same-cycle ack: set wins, no overflow.
        req = 4'b0000; tick();
        req = 4'b0001; ack = 1'b1; ack_idx = 2'd0; tick(); ack = 1'b0;
        chk_e1("set_wins", 4'b0001, 3'd1, 4'b0000);

        // Overflow beats a same-cycle ovf_clr.
        req = 4'b0000; tick();
        req = 4'b0001; ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk_e1("ovf_vs_clr", 4'b0001, 3'd1, 4'b0001);

        // All four pending.
        req = 4'b0000; tick();
        req = 4'b1111; tick();
        chk_e1("all4", 4'b1111, 3'd4, 4'b0001);
        mask = 4'b0110; #1;
        chk_e1("mask_cnt", 4'b0110, 3'd2, 4'b0001);
        mask = 4'b1111;

        // Mid-operation reset wipes state despite set/ack/ovf_clr.
        req = 4'b0000; tick();
        rst_n = 1'b0; req = 4'b0010; ack = 1'b1; ack_idx = 2'd3; ovf_clr = 1'b1; tick();
        chk_e1("mid_rst", 4'b0000, 3'd0, 4'b0000);
        rst_n = 1'b1; ack = 1'b0; ovf_clr = 1'b0; tick();
        chk_e1("post_rst", 4'b0000, 3'd0, 4'b0000);

        // Level mode.
        rst_n = 1'b0; req = 4'b0000; tick();
        chk("e0.reset", e0_pend, 4'b0000);
        rst_n = 1'b1; req = 4'b0011; tick();
        chk("e0.level", e0_pend, 4'b0011);
        chk("e0.cnt", {1'b0, e0_cnt}, 4'd2);
        ack = 1'b1; ack_idx = 2'd1; tick();
        chk("e0.set_wins", e0_pend, 4'b0011);
        chk("e0.ovf", e0_ovf, 4'b0000);
        tick();
        chk("e0.ovf_hold", e0_ovf, 4'b0000);
        ack = 1'b0; req = 4'b0000; tick();
        chk("e0.latched", e0_pend, 4'b0011);
        ack = 1'b1; ack_idx = 2'd0; tick(); ack = 1'b0;
        chk("e0.ack0", e0_pend, 4'b0010);
        chk("e0.irq", {3'b000, e0_irq}, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
